// File: rtl/tri_scan_ctrl.sv
// Triangle scanline sequencer: sorts three vertices by y, then issues one draw_line
// request per covered pixel row with the matching edge pair, top to bottom.
module tri_scan_ctrl #(
  parameter int FRAC_BITS = 5,
  parameter int Y_MAX     = 479,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tri_valid,
  output logic          tri_ready,
  input  logic [CW-1:0] v1x,
  input  logic [CW-1:0] v1y,
  input  logic [CW-1:0] v1z,
  input  logic [CW-1:0] v2x,
  input  logic [CW-1:0] v2y,
  input  logic [CW-1:0] v2z,
  input  logic [CW-1:0] v3x,
  input  logic [CW-1:0] v3y,
  input  logic [CW-1:0] v3z,
  output logic          line_start,
  input  logic          line_done,
  output logic [CW-1:0] y_coord,
  output logic [CW-1:0] pax,
  output logic [CW-1:0] pay,
  output logic [CW-1:0] paz,
  output logic [CW-1:0] pbx,
  output logic [CW-1:0] pby,
  output logic [CW-1:0] pbz,
  output logic [CW-1:0] pcx,
  output logic [CW-1:0] pcy,
  output logic [CW-1:0] pcz,
  output logic [CW-1:0] pdx,
  output logic [CW-1:0] pdy,
  output logic [CW-1:0] pdz,
  output logic          busy,
  output logic          tri_done,
  output logic [CW-1:0] rows_issued
);

  typedef enum logic [3:0] {
    IDLE, SORT0, SORT1, SORT2, SETUP, ISSUE, WAIT, RELEASE, NEXT, FIN
  } state_t;

  typedef struct packed {
    logic signed [CW-1:0] x;
    logic signed [CW-1:0] y;
    logic signed [CW-1:0] z;
  } vtx_t;

  localparam logic signed [CW-1:0] YMAX_S = CW'(Y_MAX);

  state_t               state;
  vtx_t                 p1, p2, p3;
  logic signed [CW-1:0] y_end;

  logic signed [CW-1:0] y_lo, y_hi, y_start_c, y_end_c, yf;
  logic                 upper;

  always_comb begin
    y_lo      = p1.y >>> FRAC_BITS;
    y_hi      = p3.y >>> FRAC_BITS;
    y_start_c = (y_lo < 0) ? '0 : y_lo;
    y_end_c   = (y_hi > YMAX_S) ? YMAX_S : y_hi;
    yf        = $signed(y_coord << FRAC_BITS);
    upper     = yf < p2.y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tri_ready   <= 1'b1;
      line_start  <= 1'b0;
      tri_done    <= 1'b0;
      busy        <= 1'b0;
      y_coord     <= '0;
      rows_issued <= '0;
      y_end       <= '0;
      p1          <= '0;
      p2          <= '0;
      p3          <= '0;
      pax <= '0; pay <= '0; paz <= '0;
      pbx <= '0; pby <= '0; pbz <= '0;
      pcx <= '0; pcy <= '0; pcz <= '0;
      pdx <= '0; pdy <= '0; pdz <= '0;
    end else begin
      tri_done <= 1'b0;
      case (state)
        IDLE: begin
          // ready comes back one cycle after the tri_done pulse
          tri_ready <= 1'b1;
          if (tri_valid && tri_ready) begin
            p1          <= {v1x, v1y, v1z};
            p2          <= {v2x, v2y, v2z};
            p3          <= {v3x, v3y, v3z};
            rows_issued <= '0;
            tri_ready   <= 1'b0;
            busy        <= 1'b1;
            state       <= SORT0;
          end
        end
        SORT0: begin
          if (p1.y > p2.y) begin p1 <= p2; p2 <= p1; end
          state <= SORT1;
        end
        SORT1: begin
          if (p2.y > p3.y) begin p2 <= p3; p3 <= p2; end
          state <= SORT2;
        end
        SORT2: begin
          if (p1.y > p2.y) begin p1 <= p2; p2 <= p1; end
          state <= SETUP;
        end
        SETUP: begin
          y_end <= y_end_c;
          if (y_start_c > y_end_c) begin
            state <= FIN;
          end else begin
            y_coord <= y_start_c;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          pax <= p1.x; pay <= p1.y; paz <= p1.z;
          pbx <= p3.x; pby <= p3.y; pbz <= p3.z;
          if (upper) begin
            pcx <= p1.x; pcy <= p1.y; pcz <= p1.z;
            pdx <= p2.x; pdy <= p2.y; pdz <= p2.z;
          end else begin
            pcx <= p2.x; pcy <= p2.y; pcz <= p2.z;
            pdx <= p3.x; pdy <= p3.y; pdz <= p3.z;
          end
          line_start <= 1'b1;
          state      <= WAIT;
        end
        WAIT: begin
          if (line_done) begin
            line_start <= 1'b0;
            if (rows_issued != '1) rows_issued <= rows_issued + CW'(1);
            state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!line_done) state <= NEXT;
        end
        NEXT: begin
          if ($signed(y_coord) == y_end) begin
            state <= FIN;
          end else begin
            y_coord <= y_coord + CW'(1);
            state   <= ISSUE;
          end
        end
        FIN: begin
          tri_done <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tri_scan_ctrl.sv
// Scoreboard bench for tri_scan_ctrl: a stable-sort row model feeds expectation queues,
// a negedge monitor pops them on every line_start rise and tri_done pulse.
module tb_tri_scan_ctrl;
  localparam int CW = 16;
  localparam int FB = 5;
  localparam int YM = 479;

  logic clk = 1'b0;
  logic reset;
  logic tri_valid, tri_ready, line_start, line_done, busy, tri_done;
  logic [CW-1:0] v1x, v1y, v1z, v2x, v2y, v2z, v3x, v3y, v3z;
  logic [CW-1:0] y_coord, rows_issued;
  logic [CW-1:0] pax, pay, paz, pbx, pby, pbz, pcx, pcy, pcz, pdx, pdy, pdz;

  always #5 clk = ~clk;

  tri_scan_ctrl #(.FRAC_BITS(FB), .Y_MAX(YM), .CW(CW)) dut (
    .clk(clk), .reset(reset), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .v1x(v1x), .v1y(v1y), .v1z(v1z), .v2x(v2x), .v2y(v2y), .v2z(v2z),
    .v3x(v3x), .v3y(v3y), .v3z(v3z),
    .line_start(line_start), .line_done(line_done), .y_coord(y_coord),
    .pax(pax), .pay(pay), .paz(paz), .pbx(pbx), .pby(pby), .pbz(pbz),
    .pcx(pcx), .pcy(pcy), .pcz(pcz), .pdx(pdx), .pdy(pdy), .pdz(pdz),
    .busy(busy), .tri_done(tri_done), .rows_issued(rows_issued)
  );

  typedef struct { int f[13]; } row_t;   // f[0]=row, then pa,pb,pc,pd as x,y,z
  row_t exp_rows[$];
  int   exp_cnt[$];

  int total = 0, bad = 0, done_cnt = 0;
  int lat = 4, hold = 0;
  bit spur = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int fdiv(input int v);
    int d = 1 << FB;
    return (v >= 0) ? v / d : -((-v + d - 1) / d);
  endfunction

  // Reference: stable sort by y, clip the row span, pick edge pair per row.
  function automatic int model_push(input int vx[3], input int vy[3], input int vz[3]);
    int ix[3];
    int sel[4];
    int lo, hi, n;
    row_t e;
    ix = '{0, 1, 2};
    for (int i = 1; i < 3; i++)
      for (int j = i; j > 0 && vy[ix[j-1]] > vy[ix[j]]; j--) begin
        int t = ix[j]; ix[j] = ix[j-1]; ix[j-1] = t;
      end
    lo = fdiv(vy[ix[0]]); if (lo < 0) lo = 0;
    hi = fdiv(vy[ix[2]]); if (hi > YM) hi = YM;
    n = 0;
    for (int r = lo; r <= hi; r++) begin
      sel[0] = ix[0]; sel[1] = ix[2];
      if (r * (1 << FB) < vy[ix[1]]) begin sel[2] = ix[0]; sel[3] = ix[1]; end
      else begin sel[2] = ix[1]; sel[3] = ix[2]; end
      e.f[0] = r;
      for (int k = 0; k < 4; k++) begin
        e.f[1+3*k] = vx[sel[k]]; e.f[2+3*k] = vy[sel[k]]; e.f[3+3*k] = vz[sel[k]];
      end
      exp_rows.push_back(e);
      n++;
    end
    exp_cnt.push_back(n);
    return n;
  endfunction

  // draw_line stand-in: done after `lat` cycles, held `hold` extra cycles after start drops
  initial begin
    int ph, cnt, hc;
    line_done = 1'b0; ph = 0; cnt = 0; hc = 0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin line_done = 1'b0; ph = 0; end
      else case (ph)
        0: if (line_start) begin line_done = 1'b0; cnt = lat; ph = 1; end
           else line_done = spur && !busy && ($urandom_range(1) == 1);
        1: begin cnt--; if (cnt <= 0) begin line_done = 1'b1; ph = 2; end end
        2: if (!line_start) begin hc = hold; ph = 3; end
        default: if (hc == 0) begin line_done = 1'b0; ph = 0; end else hc--;
      endcase
    end
  end

  // Monitor
  initial begin
    bit prev_ls = 1'b0, prev_td = 1'b0;
    row_t e;
    int a[13];
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (line_start && !prev_ls) begin
          chk("done_low_at_start", int'(line_done), 0);
          if (exp_rows.size() == 0) begin
            total++; bad++;
            $display("FAIL row_unexpected actual=row%0d required=none", y_coord);
          end else begin
            e = exp_rows.pop_front();
            a[0] = $signed(y_coord);
            a[1] = $signed(pax); a[2] = $signed(pay); a[3] = $signed(paz);
            a[4] = $signed(pbx); a[5] = $signed(pby); a[6] = $signed(pbz);
            a[7] = $signed(pcx); a[8] = $signed(pcy); a[9] = $signed(pcz);
            a[10] = $signed(pdx); a[11] = $signed(pdy); a[12] = $signed(pdz);
            for (int k = 0; k < 13; k++) chk($sformatf("row%0d_f%0d", e.f[0], k), a[k], e.f[k]);
          end
        end
        if (tri_done) begin
          chk("tri_done_width", int'(prev_td), 0);
          chk("busy_at_done", int'(busy), 0);
          chk("ready_at_done", int'(tri_ready), 0);
          if (exp_cnt.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected actual=%0d required=none", rows_issued);
          end else chk("rows_issued", int'(rows_issued), exp_cnt.pop_front());
          done_cnt++;
        end
      end
      prev_ls = line_start;
      prev_td = tri_done;
    end
  end

  task automatic set_verts(input int x1, y1, z1, x2, y2, z2, x3, y3, z3);
    v1x = CW'(x1); v1y = CW'(y1); v1z = CW'(z1);
    v2x = CW'(x2); v2y = CW'(y2); v2z = CW'(z2);
    v3x = CW'(x3); v3y = CW'(y3); v3z = CW'(z3);
  endtask

  task automatic rand_verts();
    set_verts($urandom_range(2000), $urandom_range(3000), $urandom_range(99),
              $urandom_range(2000), $urandom_range(3000), $urandom_range(99),
              $urandom_range(2000), $urandom_range(3000), $urandom_range(99));
  endtask

  // Present a triangle, wait for accept, check start latency; returns cycles waited for ready.
  task automatic accept_tri(input int x1, y1, z1, x2, y2, z2, x3, y3, z3,
                            input bit keep_valid, output int waits, output int n);
    int vx[3], vy[3], vz[3];
    vx = '{x1, x2, x3}; vy = '{y1, y2, y3}; vz = '{z1, z2, z3};
    n = model_push(vx, vy, vz);
    set_verts(x1, y1, z1, x2, y2, z2, x3, y3, z3);
    tri_valid = 1'b1;
    waits = 0;
    while (!tri_ready && waits < 2000) begin @(negedge clk); waits++; end
    if (!tri_ready) begin
      $display("FAIL accept_timeout actual=%0d required=ready", waits);
      bad++; total++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "no accept");
    end
    @(posedge clk); #1;
    if (!keep_valid) tri_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      if (n > 0) begin
        if (k == 4) chk("start_lat_early", int'(line_start), 0);
        if (k == 5) chk("start_lat", int'(line_start), 1);
      end else begin
        if (k == 4) chk("clip_done_early", int'(tri_done), 0);
        if (k == 5) chk("clip_done_lat", int'(tri_done), 1);
        chk("clip_no_start", int'(line_start), 0);
      end
    end
  endtask

  task automatic wait_done(input int d0, input bit scramble);
    int b = 0;
    while (done_cnt == d0 && b < 20000) begin
      @(negedge clk); #1; b++;
      if (scramble) rand_verts();
    end
    chk("done_seen", int'(done_cnt > d0), 1);
  endtask

  task automatic run_tri(input int x1, y1, z1, x2, y2, z2, x3, y3, z3);
    int w, n, d0;
    d0 = done_cnt;
    accept_tri(x1, y1, z1, x2, y2, z2, x3, y3, z3, 1'b0, w, n);
    wait_done(d0, 1'b0);
  endtask

  initial begin
    int w, n, d0, b;
    reset = 1'b1; tri_valid = 1'b0;
    set_verts(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", int'(tri_ready), 1);
    chk("rst_start", int'(line_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(tri_done), 0);
    chk("rst_y", int'(y_coord), 0);
    chk("rst_rows", int'(rows_issued), 0);
    chk("rst_p", int'({pax, pdz}), 0);
    reset = 1'b0;
    @(negedge clk); #1;

    // basic triangle, rows 2..10 with the split at row 6
    lat = 4; hold = 0;
    run_tri(320, 64, 0, 96, 320, 0, 480, 192, 0);
    // degenerate: one row, lower pairing
    run_tri(10, 160, 1, 20, 160, 2, 30, 160, 3);
    // clipping at top, bottom and fully below the screen
    run_tri(5, -64, 0, 6, 96, 0, 7, 0, 0);
    run_tri(1, 15500, 4, 2, 15200, 5, 3, 15300, 6);
    run_tri(1, 16000, 0, 2, 16500, 0, 3, 16200, 0);
    // draw_line holding done after start drops, plus stray done pulses while idle
    lat = 2; hold = 3; spur = 1'b1;
    run_tri(100, 30, 7, 200, 250, 8, 300, 100, 9);
    spur = 1'b0; hold = 0;

    // reset while waiting on row 3
    lat = 8;
    d0 = done_cnt;
    accept_tri(320, 64, 0, 96, 320, 0, 480, 192, 0, 1'b0, w, n);
    b = 0;
    while (!(line_start && y_coord == CW'(3)) && b < 2000) begin @(negedge clk); b++; end
    chk("reach_row3", int'(y_coord), 3);
    reset = 1'b1;
    @(posedge clk); #1;
    exp_rows.delete(); exp_cnt.delete();
    chk("abort_start", int'(line_start), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_ready", int'(tri_ready), 1);
    chk("abort_done", int'(tri_done), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", done_cnt, d0);
    lat = 3;
    run_tri(40, 10, 1, 50, 120, 2, 60, 60, 3);

    // tri_valid held high with scrambled vertices; next triangle only after tri_done
    d0 = done_cnt;
    accept_tri(320, 64, 0, 96, 320, 0, 480, 192, 0, 1'b1, w, n);
    wait_done(d0, 1'b1);
    d0 = done_cnt;
    accept_tri(11, 40, 3, 22, 200, 4, 33, 90, 5, 1'b0, w, n);
    chk("hold_accept_wait", w, 1);
    wait_done(d0, 1'b0);

    // randomized triangles and draw_line timing
    for (int t = 0; t < 15; t++) begin
      lat = $urandom_range(6, 1); hold = $urandom_range(3);
      run_tri(int'($urandom_range(4000)) - 2000, int'($urandom_range(2800)) - 300, $urandom_range(500),
              int'($urandom_range(4000)) - 2000, int'($urandom_range(2800)) - 300, $urandom_range(500),
              int'($urandom_range(4000)) - 2000, int'($urandom_range(2800)) - 300, $urandom_range(500));
    end

    repeat (3) @(negedge clk);
    chk("rows_left", exp_rows.size(), 0);
    chk("counts_left", exp_cnt.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
